// File: rtl/uart_tx_sched.sv
`default_nettype none
// uart_tx_sched: round-robin scheduler sharing one UART transmitter and baud generator among
// four requesters; reprograms (and restarts) the baud generator only when the rate changes.
module uart_tx_sched #(
  parameter logic [19:0] TIMEOUT = 20'd600000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [7:0]  req_baud,
  input  logic        tx_done,
  output logic [3:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  output logic [1:0]  tx_baud_rate,
  output logic        baud_rst_n,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    CFG  = 3'd2,
    LOAD = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t      state_q;
  logic [1:0]  rr_ptr_q;
  logic [7:0]  data_q;
  logic [1:0]  baud_q;
  logic [19:0] wd_q;

  logic [3:0]  grant_q;
  logic [7:0]  tx_data_q;
  logic        tx_send_q;
  logic [1:0]  tx_baud_rate_q;
  logic        baud_rst_n_q;
  logic        busy_q;
  logic        timeout_err_q;

  logic        win_valid_d;
  logic [1:0]  win_idx_d;
  logic [1:0]  scan_idx_d;
  logic [7:0]  win_data_d;
  logic [1:0]  win_baud_d;

  // Scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = rr_ptr_q;
    scan_idx_d  = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      scan_idx_d = rr_ptr_q + 2'(k);
      if (req[scan_idx_d]) begin
        win_valid_d = 1'b1;
        win_idx_d   = scan_idx_d;
      end
    end
    win_data_d = req_data[{win_idx_d, 3'b000} +: 8];
    win_baud_d = req_baud[{win_idx_d, 1'b0} +: 2];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= 2'd0;
      data_q         <= 8'd0;
      baud_q         <= 2'd0;
      wd_q           <= 20'd0;
      grant_q        <= 4'd0;
      tx_data_q      <= 8'd0;
      tx_send_q      <= 1'b0;
      tx_baud_rate_q <= 2'b10;
      baud_rst_n_q   <= 1'b1;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      grant_q       <= 4'd0;
      tx_send_q     <= 1'b0;
      baud_rst_n_q  <= 1'b1;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= ARB;
            busy_q  <= 1'b1;
          end
        end
        ARB: begin
          if (win_valid_d) begin
            grant_q  <= 4'b0001 << win_idx_d;
            data_q   <= win_data_d;
            baud_q   <= win_baud_d;
            rr_ptr_q <= win_idx_d + 2'd1;
            state_q  <= (win_baud_d != tx_baud_rate_q) ? CFG : LOAD;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        CFG: begin
          tx_baud_rate_q <= baud_q;
          baud_rst_n_q   <= 1'b0;
          state_q        <= LOAD;
        end
        LOAD: begin
          tx_data_q <= data_q;
          tx_send_q <= 1'b1;
          wd_q      <= 20'd0;
          state_q   <= WAIT;
        end
        WAIT: begin
          // tx_done is checked first so a completion on the expiry cycle is not an error.
          if (tx_done) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wd_q == TIMEOUT - 20'd1) begin
            timeout_err_q <= 1'b1;
            state_q       <= IDLE;
            busy_q        <= 1'b0;
          end else begin
            wd_q <= wd_q + 20'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant        = grant_q;
  assign tx_data      = tx_data_q;
  assign tx_send      = tx_send_q;
  assign tx_baud_rate = tx_baud_rate_q;
  assign baud_rst_n   = baud_rst_n_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// tb_uart_tx_sched: randomized rounds of requests; a reference model predicts the grant
// sequence and frame timing into a queue that an independent monitor pops and compares.
module tb_uart_tx_sched;

  localparam int M_NORMAL = 0;
  localparam int M_TO     = 1;
  localparam int M_COINC  = 2;
  localparam int M_RST    = 3;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic [1:0] baud;
    logic       chg;
    logic [1:0] mode;
    logic [4:0] d;
  } frame_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [7:0]  req_baud;
  logic        tx_done;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic [1:0]  tx_baud_rate;
  logic        baud_rst_n;
  logic        busy;
  logic        timeout_err;

  uart_tx_sched #(.TIMEOUT(20'd16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req          (req),
    .req_data     (req_data),
    .req_baud     (req_baud),
    .tx_done      (tx_done),
    .grant        (grant),
    .tx_data      (tx_data),
    .tx_send      (tx_send),
    .tx_baud_rate (tx_baud_rate),
    .baud_rst_n   (baud_rst_n),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  frame_t exp_q[$];
  frame_t resp_q[$];
  bit     mon_busy = 1'b0;

  // Model state: next round-robin start and the rate the generator currently holds.
  int         m_ptr  = 0;
  logic [1:0] m_baud = 2'b10;

  // Round hand-off to the client process.
  int         round_id = 0;
  logic [3:0] req_set_v = 4'd0;
  int         hold_v = 0;
  int         poke_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic finish_sim();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  endtask

  task automatic check_reset_vals();
    chk("rst_grant", grant, 4'd0);
    chk("rst_tx_data", tx_data, 8'd0);
    chk("rst_tx_send", tx_send, 1'b0);
    chk("rst_tx_baud_rate", tx_baud_rate, 2'b10);
    chk("rst_baud_rst_n", baud_rst_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
  endtask

  // Predict the grant order for one round: cyclic scan of the pending set from the pointer.
  task automatic plan_round(input logic [3:0] set, input bit hold, input int n, input int mode_sel,
                            input bit forced, input logic [31:0] fdata, input logic [7:0] fbaud);
    logic [3:0] pend;
    int         j;
    int         md;
    int         r;
    frame_t     e;
    if (forced) begin
      req_data = fdata;
      req_baud = fbaud;
    end else begin
      req_data = $urandom;
      req_baud = 8'($urandom);
    end
    pend = set;
    for (int g = 0; g < n; g++) begin
      j = -1;
      for (int s = 0; s < 4; s++)
        if (j < 0 && pend[(m_ptr + s) % 4]) j = (m_ptr + s) % 4;
      if (j < 0) break;
      e.idx  = 2'(j);
      e.data = req_data[8*j +: 8];
      e.baud = req_baud[2*j +: 2];
      e.chg  = (e.baud != m_baud);
      m_baud = e.baud;
      m_ptr  = (j + 1) % 4;
      if (!hold) pend[j] = 1'b0;
      if (mode_sel >= 0) md = mode_sel;
      else begin
        r  = $urandom_range(0, 9);
        md = (r < 8) ? M_NORMAL : (r == 8) ? M_TO : M_COINC;
      end
      e.mode = 2'(md);
      e.d    = (md == M_COINC) ? 5'd15 : 5'($urandom_range(1, 12));
      exp_q.push_back(e);
      resp_q.push_back(e);
    end
  endtask

  task automatic start_round(input logic [3:0] set, input int hold_n);
    req_set_v = set;
    hold_v    = hold_n;
    round_id++;
  endtask

  task automatic wait_drain();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while ((exp_q.size() != 0 || mon_busy || busy) && t < 3000);
    if (t >= 3000) begin
      chk("drain_timeout", 32'd0, 32'd1);
      finish_sim();
    end
    repeat (2) @(negedge clock);
  endtask

  // Client: holds each request until its grant (or for a fixed number of grants in hold rounds).
  initial begin : client
    int seen = 0;
    int cnt  = 0;
    req = 4'd0;
    forever begin
      @(negedge clock);
      if (round_id != seen) begin
        seen = round_id;
        req  = req_set_v;
        cnt  = hold_v;
      end else if (grant != 4'd0) begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) req = 4'd0;
        end else begin
          req = req & ~grant;
        end
      end
    end
  end

  // Transmitter stand-in: answers tx_send after the delay planned for that frame.
  initial begin : responder
    frame_t r;
    int     poke_ack = 0;
    tx_done = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_send && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        if (r.mode == M_NORMAL || r.mode == M_COINC) begin
          repeat (int'(r.d)) @(negedge clock);
          tx_done = 1'b1;
          @(negedge clock);
          tx_done = 1'b0;
        end
      end else if (poke_req != poke_ack) begin
        poke_ack = poke_req;
        tx_done  = 1'b1;
        @(negedge clock);
        tx_done  = 1'b0;
      end
    end
  end

  initial begin : monitor
    frame_t e;
    logic   bad;
    int     fin;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (grant != 4'd0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_grant", grant, 4'd0);
          end else begin
            mon_busy = 1'b1;
            e = exp_q.pop_front();
            chk("grant", grant, 4'b0001 << e.idx);
            chk("busy_at_grant", busy, 1'b1);
            if (e.chg) begin
              @(negedge clock);
              chk("cfg_baud_rst_n", baud_rst_n, 1'b0);
              chk("cfg_tx_baud_rate", tx_baud_rate, e.baud);
              chk("cfg_no_send", tx_send, 1'b0);
            end
            @(negedge clock);
            chk("tx_send", tx_send, 1'b1);
            chk("tx_data", tx_data, e.data);
            chk("send_baud_rst_n", baud_rst_n, 1'b1);
            chk("send_tx_baud_rate", tx_baud_rate, e.baud);
            if (e.mode == M_RST) begin
              fin = 0;
              while (reset_n && fin < 200) begin @(negedge clock); fin++; end
              while (!reset_n && fin < 400) begin @(negedge clock); fin++; end
              if (fin >= 200) chk("reset_window", 32'd0, 32'd1);
            end else begin
              fin = (e.mode == M_TO) ? 16 : int'(e.d) + 1;
              bad = 1'b0;
              for (int k = 1; k < fin; k++) begin
                @(negedge clock);
                if (busy !== 1'b1 || timeout_err !== 1'b0 || tx_send !== 1'b0 ||
                    grant !== 4'd0 || baud_rst_n !== 1'b1 || tx_baud_rate !== e.baud)
                  bad = 1'b1;
              end
              @(negedge clock);
              chk("frame_quiet", bad, 1'b0);
              chk("busy_after_end", busy, 1'b0);
              chk("timeout_err", timeout_err, (e.mode == M_TO) ? 32'd1 : 32'd0);
            end
            mon_busy = 1'b0;
          end
        end else if (tx_send || !baud_rst_n || timeout_err) begin
          chk("stray_pulse", {tx_send, baud_rst_n, timeout_err}, 3'b010);
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    chk("global_timeout", 32'd0, 32'd1);
    finish_sim();
  end

  initial begin : stimulus
    int         t;
    logic [3:0] set;
    reset_n  = 1'b0;
    req_data = 32'd0;
    req_baud = 8'd0;
    repeat (3) @(negedge clock);
    check_reset_vals();
    #2 reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Same rate as reset default: no reprogramming.
    plan_round(4'b0001, 1'b0, 1, M_NORMAL, 1'b1, 32'h0000_00A5, 8'b0000_0010);
    start_round(4'b0001, 0);
    wait_drain();

    // Rate change on requester 2; pointer then sits at 3.
    plan_round(4'b0100, 1'b0, 1, M_NORMAL, 1'b1, 32'h003C_0000, 8'b0000_0000);
    start_round(4'b0100, 0);
    wait_drain();

    // Pointer wrap: requester 0 must win over requester 2.
    plan_round(4'b0101, 1'b0, 2, -1, 1'b0, 32'd0, 8'd0);
    start_round(4'b0101, 0);
    wait_drain();

    // Watchdog expiry, then completion landing on the expiry cycle.
    plan_round(4'b0010, 1'b0, 1, M_TO, 1'b0, 32'd0, 8'd0);
    start_round(4'b0010, 0);
    wait_drain();
    plan_round(4'b1000, 1'b0, 1, M_COINC, 1'b0, 32'd0, 8'd0);
    start_round(4'b1000, 0);
    wait_drain();

    // tx_done while idle must be ignored.
    poke_req++;
    repeat (4) @(negedge clock);

    // Reset in the middle of WAIT, then a held 4'b1111 round from a cleared pointer.
    plan_round(4'b0001, 1'b0, 1, M_RST, 1'b0, 32'd0, 8'd0);
    start_round(4'b0001, 0);
    t = 0;
    while (!tx_send && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) begin
      chk("reach_wait", 32'd0, 32'd1);
      finish_sim();
    end
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_reset_vals();
    m_ptr  = 0;
    m_baud = 2'b10;
    plan_round(4'b1111, 1'b1, 5, -1, 1'b0, 32'd0, 8'd0);
    start_round(4'b1111, 5);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    wait_drain();

    for (int i = 0; i < 25; i++) begin
      set = 4'($urandom_range(1, 15));
      plan_round(set, 1'b0, $countones(set), -1, 1'b0, 32'd0, 8'd0);
      start_round(set, 0);
      wait_drain();
    end

    finish_sim();
  end

endmodule
`default_nettype wire
